// File: rtl/msu_pkg.sv
// Shared definitions for the MSU sector streamer: FSM state encodings and
// sector geometry helpers.
package msu_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE       = 3'd0;
    localparam state_t S_WAIT_MOUNT = 3'd1;
    localparam state_t S_REQ        = 3'd2;
    localparam state_t S_XFER       = 3'd3;
    localparam state_t S_NEXT       = 3'd4;
    localparam state_t S_DRAIN      = 3'd5;

    function automatic int words_per_sector(input int sector_bytes);
        return sector_bytes / 2;
    endfunction

    // One extra bit so the index can reach words_per_sector itself.
    function automatic int word_idx_w(input int sector_bytes);
        return $clog2(sector_bytes / 2) + 1;
    endfunction

endpackage

// File: rtl/msu_track_geom.sv
// Converts track size and loop point into sector/word coordinates, captured
// on load so the values are stable for the whole play-through.
module msu_track_geom
    import msu_pkg::*;
#(
    parameter  int SECTOR_BYTES     = 512,
    parameter  int LBA_W            = 21,
    parameter  int HDR_BYTES        = 8,
    parameter  int BYTES_PER_SAMPLE = 4,
    localparam int IDX_W            = word_idx_w(SECTOR_BYTES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [31:0]       img_size,
    input  logic [31:0]       loop_sample,
    output logic [LBA_W-1:0]  end_lba,
    output logic [IDX_W-1:0]  end_words,
    output logic [LBA_W-1:0]  loop_lba,
    output logic [IDX_W-1:0]  loop_skip,
    output logic              hdr_only
);

    localparam int          SB_LOG  = $clog2(SECTOR_BYTES);
    localparam logic [31:0] SB_MASK = 32'(SECTOR_BYTES - 1);
    localparam logic [31:0] HDR32   = 32'(HDR_BYTES);
    localparam logic [31:0] BPS32   = 32'(BYTES_PER_SAMPLE);
    localparam logic [31:0] LBA_MAX = (LBA_W >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << LBA_W) - 32'd1);

    logic [31:0]      last_byte;
    logic [31:0]      end_lba_full;
    logic [31:0]      loop_byte;
    logic [31:0]      loop_lba_full;
    logic [LBA_W-1:0] end_lba_d,   end_lba_q;
    logic [IDX_W-1:0] end_words_d, end_words_q;
    logic [LBA_W-1:0] loop_lba_d,  loop_lba_q;
    logic [IDX_W-1:0] loop_skip_d, loop_skip_q;
    logic             hdr_only_d,  hdr_only_q;

    // NOTE: every variable gets a value before any condition, so no path
    // through this block can leave one unassigned and infer a latch.
    always_comb begin
        last_byte     = img_size - 32'd1;
        end_lba_full  = last_byte >> SB_LOG;
        loop_byte     = HDR32 + loop_sample * BPS32;
        if (loop_byte >= img_size) begin
            loop_byte = HDR32;
        end
        loop_lba_full = loop_byte >> SB_LOG;

        end_lba_d   = (end_lba_full > LBA_MAX) ? LBA_W'(LBA_MAX) : LBA_W'(end_lba_full);
        loop_lba_d  = (loop_lba_full > LBA_MAX) ? LBA_W'(LBA_MAX) : LBA_W'(loop_lba_full);
        end_words_d = IDX_W'((last_byte & SB_MASK) >> 1) + 1'b1;
        loop_skip_d = IDX_W'((loop_byte & SB_MASK) >> 1);
        hdr_only_d  = (img_size <= HDR32);
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values,
    // independent of the order the statements are written in.
    always_ff @(posedge clk) begin
        if (!reset) begin
            end_lba_q   <= '0;
            end_words_q <= '0;
            loop_lba_q  <= '0;
            loop_skip_q <= '0;
            hdr_only_q  <= 1'b0;
        end else if (load) begin
            end_lba_q   <= end_lba_d;
            end_words_q <= end_words_d;
            loop_lba_q  <= loop_lba_d;
            loop_skip_q <= loop_skip_d;
            hdr_only_q  <= hdr_only_d;
        end
    end

    assign end_lba   = end_lba_q;
    assign end_words = end_words_q;
    assign loop_lba  = loop_lba_q;
    assign loop_skip = loop_skip_q;
    assign hdr_only  = hdr_only_q;

endmodule

// File: rtl/msu_sector_streamer.sv
// Sector-by-sector PCM fetch from the SD buffer with byte-exact header,
// tail and loop trimming, plus stop/pause/backpressure and safe retrigger.
module msu_sector_streamer
    import msu_pkg::*;
#(
    parameter int SECTOR_BYTES     = 512,
    parameter int LBA_W            = 21,
    parameter int USEDW_W          = 12,
    parameter int FIFO_HIWAT       = 1792,
    parameter int HDR_BYTES        = 8,
    parameter int BYTES_PER_SAMPLE = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        img_size,
    input  logic [31:0]        loop_sample,
    input  logic               repeat_en,
    input  logic               play,
    input  logic               stop,
    input  logic               pause,
    input  logic               mounted,
    input  logic               sd_ack,
    input  logic               sd_buff_wr,
    input  logic [USEDW_W-1:0] fifo_usedw,
    output logic [LBA_W-1:0]   sd_lba,
    output logic               sd_rd,
    output logic               word_keep,
    output logic               playing,
    output logic               loop_pulse,
    output logic               done_pulse
);

    localparam int               IDX_W    = word_idx_w(SECTOR_BYTES);
    localparam logic [IDX_W-1:0] WP_W     = IDX_W'(words_per_sector(SECTOR_BYTES));
    localparam logic [IDX_W-1:0] HDR_SKIP = IDX_W'(HDR_BYTES / 2);
    localparam logic [31:0]      HIWAT32  = 32'(FIFO_HIWAT);

    state_t           state_d, state_q;
    logic             to_mount_d, to_mount_q;
    logic [LBA_W-1:0] cur_lba_d, cur_lba_q;
    logic [IDX_W-1:0] skip_d, skip_q;
    logic [IDX_W-1:0] word_idx_d, word_idx_q;
    logic             ack_d, ack_q;
    logic             repeat_d, repeat_q;

    logic             load;
    logic             blocked;
    logic             loop_c, done_c;
    logic [IDX_W-1:0] limit;
    logic [LBA_W-1:0] end_lba, loop_lba;
    logic [IDX_W-1:0] end_words, loop_skip;
    logic             hdr_only;

    assign load = play & ~stop;

    msu_track_geom #(
        .SECTOR_BYTES    (SECTOR_BYTES),
        .LBA_W           (LBA_W),
        .HDR_BYTES       (HDR_BYTES),
        .BYTES_PER_SAMPLE(BYTES_PER_SAMPLE)
    ) u_geom (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .img_size   (img_size),
        .loop_sample(loop_sample),
        .end_lba    (end_lba),
        .end_words  (end_words),
        .loop_lba   (loop_lba),
        .loop_skip  (loop_skip),
        .hdr_only   (hdr_only)
    );

    assign blocked = pause | (32'(fifo_usedw) >= HIWAT32);
    assign limit   = (cur_lba_q == end_lba) ? end_words : WP_W;

    always_comb begin
        state_d    = state_q;
        to_mount_d = to_mount_q;
        cur_lba_d  = cur_lba_q;
        skip_d     = skip_q;
        word_idx_d = word_idx_q;
        ack_d      = sd_ack;
        repeat_d   = load ? repeat_en : repeat_q;
        loop_c     = 1'b0;
        done_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load) state_d = S_WAIT_MOUNT;
            end
            S_WAIT_MOUNT: begin
                if (mounted) begin
                    if (hdr_only) begin
                        done_c  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cur_lba_d = '0;
                        skip_d    = HDR_SKIP;
                        ack_d     = 1'b0;
                        state_d   = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (sd_ack & ~ack_q) begin
                    word_idx_d = '0;
                    state_d    = S_XFER;
                end
            end
            S_XFER: begin
                if (sd_buff_wr) word_idx_d = word_idx_q + 1'b1;
                if (~sd_ack & ack_q) begin
                    skip_d  = '0;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (!blocked) begin
                    if (cur_lba_q < end_lba) begin
                        cur_lba_d = cur_lba_q + 1'b1;
                        ack_d     = 1'b0;
                        state_d   = S_REQ;
                    end else if (repeat_q) begin
                        loop_c    = 1'b1;
                        cur_lba_d = loop_lba;
                        skip_d    = loop_skip;
                        ack_d     = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        done_c  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (!sd_ack) state_d = to_mount_q ? S_WAIT_MOUNT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort paths override whatever the state decided; stop beats play.
        if (state_q != S_IDLE && (stop || play)) begin
            state_d    = S_DRAIN;
            to_mount_d = ~stop;
            loop_c     = 1'b0;
            done_c     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            to_mount_q <= 1'b0;
            cur_lba_q  <= '0;
            skip_q     <= '0;
            word_idx_q <= '0;
            ack_q      <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            to_mount_q <= to_mount_d;
            cur_lba_q  <= cur_lba_d;
            skip_q     <= skip_d;
            word_idx_q <= word_idx_d;
            ack_q      <= ack_d;
            repeat_q   <= repeat_d;
        end
    end

    // Outputs are qualified by reset so a reset asserted mid-transfer
    // releases the SD request in the same cycle.
    assign sd_rd      = reset & (state_q == S_REQ);
    assign sd_lba     = {LBA_W{reset}} & cur_lba_q;
    assign playing    = reset & (state_q != S_IDLE);
    assign loop_pulse = reset & loop_c;
    assign done_pulse = reset & done_c;
    assign word_keep  = reset & (state_q == S_XFER) & sd_buff_wr & sd_ack
                        & (word_idx_q >= skip_q) & (word_idx_q < limit);

endmodule
